// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared types and constants for the muldiv_hilo unit
//
// Purpose: op encoding, FSM state encoding, iteration count and counter
// width helper shared by muldiv_hilo and muldiv_step.
// Ports: none (package).
// Configuration: MULDIV_ABORT_EN (see muldiv_hilo) does not affect this file.

package muldiv_pkg;

  // Default operand width; the top level may override it.
  localparam int MD_XLEN = 32;

  // One radix-2 step per operand bit.
  localparam int ITER_CNT = MD_XLEN;

  // Counter must be able to hold 0..ITER_CNT.
  function automatic int cnt_width(input int xlen);
    return $clog2(xlen + 1);
  endfunction

  localparam int CNT_W = cnt_width(ITER_CNT);

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ITER  = 2'd1,
    ST_FIXUP = 2'd2
  } md_state_e;

  // MULT and DIV operate on two's-complement operands.
  function automatic logic op_is_signed(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one combinational shift-add / restoring-divide step
//
// Purpose: advances the 2*XLEN accumulator by one iteration.
//   multiply: acc = {partial_hi, multiplier_remaining}; adds the
//             multiplicand to the high half when acc[0]=1, then shifts right.
//   divide:   acc = {remainder, dividend_remaining/quotient}; shifts left
//             and subtracts the divisor from the remainder when it fits.
// Ports:
//   is_div_i  1        0 = multiply step, 1 = divide step
//   acc_i     2*XLEN   accumulator before the step
//   opnd_i    XLEN     multiplicand (mult) or divisor (div) magnitude
//   acc_o     2*XLEN   accumulator after the step (div: bit 0 left at 0)
//   q_bit_o   1        quotient bit produced by a divide step (0 for mult)

module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic              is_div_i,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   opnd_i,
  output logic [2*XLEN-1:0] acc_o,
  output logic              q_bit_o
);

  logic [XLEN:0]   add_sum;
  logic [2*XLEN:0] shl;
  logic [XLEN:0]   trial;

  always_comb begin
    // The add keeps its carry so the right shift loses nothing.
    add_sum = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, opnd_i} : '0);

    // Shifted remainder needs XLEN+1 bits; bit XLEN of the trial
    // difference is the borrow that says the divisor did not fit.
    shl   = {acc_i, 1'b0};
    trial = shl[2*XLEN:XLEN] - {1'b0, opnd_i};

    acc_o   = '0;
    q_bit_o = 1'b0;
    if (is_div_i) begin
      if (!trial[XLEN]) begin
        q_bit_o = 1'b1;
        acc_o   = {trial[XLEN-1:0], shl[XLEN-1:0]};
      end else begin
        acc_o   = shl[2*XLEN-1:0];
      end
    end else begin
      acc_o = {add_sum, acc_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_hilo.sv
// rtl/muldiv_hilo.sv - multi-cycle multiply/divide unit owning HI/LO
//
// Purpose: accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO, iterates one bit per cycle
// and writes {HI,LO}. Start edge, 32 ITER edges, one FIXUP edge; result,
// done pulse and busy=0 all appear in the cycle after FIXUP.
// Ports:
//   clk_cpu  in   1       CPU clock
//   reset    in   1       synchronous active-high reset
//   start    in   1       op request, honoured only when busy=0
//   op       in   3       0 MULT,1 MULTU,2 DIV,3 DIVU,4 MTHI,5 MTLO (6,7 ignored)
//   src_rs   in   XLEN    dividend / multiplicand / MT source
//   src_rt   in   XLEN    divisor / multiplier
//   busy     out  1       iteration in progress
//   done     out  1       one-cycle pulse when mult/div writes HI/LO
//   hilo_q   out  2*XLEN  {HI,LO}
//   abort    in   1       only with MULDIV_ABORT_EN: drop the iteration
// Configuration: define MULDIV_ABORT_EN to add the abort port.

module muldiv_hilo
  import muldiv_pkg::*;
#(
  parameter int                XLEN     = MD_XLEN,
  parameter logic [2*XLEN-1:0] HILO_RST = '0
) (
  input  logic              clk_cpu,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [XLEN-1:0]   src_rs,
  input  logic [XLEN-1:0]   src_rt,
  output logic              busy,
  output logic              done,
  output logic [2*XLEN-1:0] hilo_q
`ifdef MULDIV_ABORT_EN
  ,
  input  logic              abort
`endif
);

  localparam int CW = cnt_width(XLEN);

  md_state_e         state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic              is_div_q, is_div_d;
  logic              neg_q, neg_d;          // product / quotient negative
  logic              rem_neg_q, rem_neg_d;  // remainder negative
  logic              div0_q, div0_d;
  logic              done_q, done_d;
  logic [2*XLEN-1:0] hilo_d;

  logic              abort_w;
  logic              sgn;
  logic              rs_neg, rt_neg;
  logic [XLEN-1:0]   rs_mag, rt_mag;
  logic [2*XLEN-1:0] step_acc;
  logic              step_qbit;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s, rem_s;
  logic [2*XLEN-1:0] fix_res;

`ifdef MULDIV_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;

  // Operand preparation: signed ops iterate on magnitudes.
  assign sgn    = op_is_signed(op);
  assign rs_neg = sgn & src_rs[XLEN-1];
  assign rt_neg = sgn & src_rt[XLEN-1];
  assign rs_mag = rs_neg ? -src_rs : src_rs;
  assign rt_mag = rt_neg ? -src_rt : src_rt;

  muldiv_step #(
    .XLEN (XLEN)
  ) u_step (
    .is_div_i (is_div_q),
    .acc_i    (acc_q),
    .opnd_i   (opnd_q),
    .acc_o    (step_acc),
    .q_bit_o  (step_qbit)
  );

  // Sign fixup. A most-negative magnitude negates to itself, which gives
  // the required 0x80000000 quotient for 0x80000000 / -1 without a special case.
  // Divide by zero iterates naturally to remainder = |rs| (so HI = rs after
  // sign fixup); only LO needs forcing to all ones.
  assign prod_s  = neg_q ? -acc_q : acc_q;
  assign quo_s   = div0_q ? '1 : (neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0]);
  assign rem_s   = rem_neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
  assign fix_res = is_div_q ? {rem_s, quo_s} : prod_s;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    div0_d    = div0_q;
    done_d    = 1'b0;
    hilo_d    = hilo_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (op)
            MD_MTHI: hilo_d[2*XLEN-1:XLEN] = src_rs;
            MD_MTLO: hilo_d[XLEN-1:0]      = src_rs;
            MD_MULT, MD_MULTU: begin
              state_d   = ST_ITER;
              cnt_d     = '0;
              is_div_d  = 1'b0;
              acc_d     = {{XLEN{1'b0}}, rt_mag};
              opnd_d    = rs_mag;
              neg_d     = rs_neg ^ rt_neg;
              rem_neg_d = 1'b0;
              div0_d    = 1'b0;
            end
            MD_DIV, MD_DIVU: begin
              state_d   = ST_ITER;
              cnt_d     = '0;
              is_div_d  = 1'b1;
              acc_d     = {{XLEN{1'b0}}, rs_mag};
              opnd_d    = rt_mag;
              neg_d     = rs_neg ^ rt_neg;
              rem_neg_d = rs_neg;
              div0_d    = (src_rt == '0);
            end
            default: ;
          endcase
        end
      end
      ST_ITER: begin
        // The step leaves bit 0 clear on divide; the quotient bit lands there.
        acc_d = is_div_q ? {step_acc[2*XLEN-1:1], step_qbit} : step_acc;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(XLEN - 1)) begin
          state_d = ST_FIXUP;
        end
      end
      ST_FIXUP: begin
        hilo_d  = fix_res;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Flush: drop the operation without touching HI/LO.
    if (abort_w && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      hilo_d  = hilo_q;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_cpu) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      div0_q    <= 1'b0;
      done_q    <= 1'b0;
      hilo_q    <= HILO_RST;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      div0_q    <= div0_d;
      done_q    <= done_d;
      hilo_q    <= hilo_d;
    end
  end

endmodule

// File: tb/tb_muldiv_hilo.sv
// tb/tb_muldiv_hilo.sv - self-checking bench for muldiv_hilo
//
// Purpose: directed and random mult/div/MT ops; expected {HI,LO} values are
// queued at issue and popped when done pulses. Define MULDIV_ABORT_EN to
// also exercise the abort port.

module tb_muldiv_hilo;
  import muldiv_pkg::*;

  localparam logic [63:0] HILO_RST = 64'h0;

  logic        clk_cpu = 1'b0;
  logic        reset   = 1'b1;
  logic        start   = 1'b0;
  logic [2:0]  op      = 3'd0;
  logic [31:0] src_rs  = '0;
  logic [31:0] src_rt  = '0;
  logic        busy;
  logic        done;
  logic [63:0] hilo_q;
`ifdef MULDIV_ABORT_EN
  logic        abort   = 1'b0;
`endif

  int          checks    = 0;
  int          failures  = 0;
  int          done_cnt  = 0;
  logic [63:0] sb[$];
  logic [63:0] exp_hilo;
  logic [63:0] mon_exp;

  muldiv_hilo #(
    .XLEN     (32),
    .HILO_RST (HILO_RST)
  ) dut (
    .clk_cpu (clk_cpu),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .src_rs  (src_rs),
    .src_rt  (src_rt),
    .busy    (busy),
    .done    (done),
    .hilo_q  (hilo_q)
`ifdef MULDIV_ABORT_EN
    ,
    .abort   (abort)
`endif
  );

  always #5 clk_cpu = ~clk_cpu;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Scoreboard side: sample 2 time units after the rising edge.
  always begin
    @(posedge clk_cpu);
    #2;
    if (done === 1'b1) begin
      done_cnt++;
      checks++;
      assert (sb.size() != 0) else begin
        failures++;
        $error("FAIL done_unexpected observed_hilo=%h expected=no_done", hilo_q);
      end
      if (sb.size() != 0) begin
        mon_exp = sb.pop_front();
        checks++;
        assert (hilo_q === mon_exp) else begin
          failures++;
          $error("FAIL result observed=%h expected=%h", hilo_q, mon_exp);
        end
      end
    end
  end

  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sbv, q, r;
    logic [63:0] ua, ub;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    ua  = {32'h0, a};
    ub  = {32'h0, b};
    case (o)
      MD_MULT:  return 64'(sa * sbv);
      MD_MULTU: return ua * ub;
      MD_DIV: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        q = sa / sbv;
        r = sa % sbv;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        return {32'(ua % ub), 32'(ua / ub)};
      end
    endcase
  endfunction

  // Drives start for one edge; returns at the falling edge after it.
  task automatic start_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk_cpu);
    start  = 1'b1;
    op     = o;
    src_rs = a;
    src_rt = b;
    @(negedge clk_cpu);
    start  = 1'b0;
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] expv, input string tag, input int second_at);
    int n;
    int d0;
    sb.push_back(expv);
    d0 = done_cnt;
    start_op(o, a, b);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      if (n == 3) chk({tag, "_hold"}, hilo_q, exp_hilo);
      if (n == second_at) begin
        start  = 1'b1;
        op     = MD_MULTU;
        src_rs = 32'h7;
        src_rt = 32'h9;
      end else begin
        start  = 1'b0;
      end
      @(negedge clk_cpu);
    end
    start = 1'b0;
    chk({tag, "_busy_cycles"}, 64'(n), 64'd33);
    chk({tag, "_done_high"}, 64'(done), 64'd1);
    @(negedge clk_cpu);
    chk({tag, "_done_low"}, 64'(done), 64'd0);
    chk({tag, "_done_count"}, 64'(done_cnt - d0), 64'd1);
    exp_hilo = expv;
  endtask

  initial begin
    int d0;
    logic [2:0]  ro;
    logic [31:0] ra, rb;

    repeat (3) @(negedge clk_cpu);
    chk("rst_hilo", hilo_q, HILO_RST);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    reset    = 1'b0;
    exp_hilo = HILO_RST;

    run_op(MD_MULT,  32'hFFFF_FFFD, 32'd5,         64'hFFFF_FFFF_FFFF_FFF1, "mult_neg", 0);
    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "multu_max", 0);
    run_op(MD_DIV,   32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD, "div_neg", 0);
    run_op(MD_DIVU,  32'd100,       32'd0,         64'h0000_0064_FFFF_FFFF, "divu_zero", 0);
    run_op(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, "div_ovf", 0);

    // MTHI / MTLO take effect at the start edge with no busy or done.
    start_op(MD_MTHI, 32'h1234_5678, 32'h0);
    exp_hilo = {32'h1234_5678, exp_hilo[31:0]};
    chk("mthi_hilo", hilo_q, exp_hilo);
    chk("mthi_busy", 64'(busy), 64'd0);
    chk("mthi_done", 64'(done), 64'd0);
    start_op(MD_MTLO, 32'hCAFE_F00D, 32'h0);
    exp_hilo = {exp_hilo[63:32], 32'hCAFE_F00D};
    chk("mtlo_hilo", hilo_q, exp_hilo);
    chk("mtlo_busy", 64'(busy), 64'd0);

    // Invalid op codes change nothing.
    start_op(3'd7, 32'hDEAD_BEEF, 32'h3);
    chk("inv_hilo", hilo_q, exp_hilo);
    chk("inv_busy", 64'(busy), 64'd0);
    @(negedge clk_cpu);
    chk("inv_done", 64'(done), 64'd0);

    // A start while busy is dropped.
    run_op(MD_MULT, 32'd1000, 32'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_F830, "mult_2nd_start", 5);
    chk("after_2nd_busy", 64'(busy), 64'd0);

    for (int i = 0; i < 8; i++) begin
      ro = 3'(i % 4);
      ra = $urandom;
      rb = $urandom;
      if (ro >= MD_DIV) rb = rb >> $urandom_range(0, 28);
      run_op(ro, ra, rb, model(ro, ra, rb), $sformatf("rand%0d", i), 0);
    end

    // Reset during an iteration: no write, back to HILO_RST.
    d0 = done_cnt;
    start_op(MD_DIVU, 32'd1000, 32'd7);
    repeat (9) @(negedge clk_cpu);
    reset = 1'b1;
    @(negedge clk_cpu);
    reset = 1'b0;
    chk("midrst_hilo", hilo_q, HILO_RST);
    chk("midrst_busy", 64'(busy), 64'd0);
    exp_hilo = HILO_RST;
    repeat (40) @(negedge clk_cpu);
    chk("midrst_no_done", 64'(done_cnt - d0), 64'd0);

`ifdef MULDIV_ABORT_EN
    run_op(MD_MULTU, 32'd6, 32'd7, 64'd42, "pre_abort", 0);
    d0 = done_cnt;
    start_op(MD_DIVU, 32'd5000, 32'd3);
    repeat (9) @(negedge clk_cpu);
    abort = 1'b1;
    @(negedge clk_cpu);
    abort = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_hilo", hilo_q, exp_hilo);
    repeat (40) @(negedge clk_cpu);
    chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
    chk("abort_hilo_late", hilo_q, exp_hilo);
    @(negedge clk_cpu);
    abort = 1'b1;
    @(negedge clk_cpu);
    abort = 1'b0;
    chk("abort_idle_hilo", hilo_q, exp_hilo);
`endif

    repeat (5) @(negedge clk_cpu);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
